// File: rtl/alu_sequencer.sv
// alu_sequencer: expands 16-bit macro-ops (ADD, AND, NOT, SUB, OR, XOR, NEG, PASS)
// into sequences of native ALU micro-ops (ADD, AND, NOT A) on a shared
// combinational ALU, using scratch registers T, U and V.
// One request at a time; the result is returned over a valid/ready handshake.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Macro-op encodings
  localparam logic [2:0] M_ADD  = 3'd0;
  localparam logic [2:0] M_AND  = 3'd1;
  localparam logic [2:0] M_NOT  = 3'd2;
  localparam logic [2:0] M_SUB  = 3'd3;
  localparam logic [2:0] M_OR   = 3'd4;
  localparam logic [2:0] M_XOR  = 3'd5;
  localparam logic [2:0] M_NEG  = 3'd6;
  localparam logic [2:0] M_PASS = 3'd7;

  // Native ALU operations
  localparam logic [1:0] A_ADD = 2'b00;
  localparam logic [1:0] A_AND = 2'b01;
  localparam logic [1:0] A_NOT = 2'b10;

  // Micro-op destinations
  localparam logic [1:0] D_T = 2'd0;
  localparam logic [1:0] D_U = 2'd1;
  localparam logic [1:0] D_V = 2'd2;
  localparam logic [1:0] D_R = 2'd3;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [2:0]       op_r;
  logic [2:0]       step_r;
  logic [WIDTH-1:0] ra_r, rb_r, t_r, u_r, v_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             busy_r;

  logic [1:0]       uop_s;
  logic [WIDTH-1:0] ua_s, ub_s;
  logic [1:0]       dst_s;
  logic             last_s;

  // Decode the current micro-op from registered state only; ALU idles outside EXEC
  always_comb begin
    uop_s  = A_ADD;
    ua_s   = ZERO;
    ub_s   = ZERO;
    dst_s  = D_R;
    last_s = 1'b1;
    if (state_r == S_EXEC) begin
      case (op_r)
        M_ADD:  begin uop_s = A_ADD; ua_s = ra_r; ub_s = rb_r; end
        M_AND:  begin uop_s = A_AND; ua_s = ra_r; ub_s = rb_r; end
        M_NOT:  begin uop_s = A_NOT; ua_s = ra_r; end
        M_PASS: begin uop_s = A_ADD; ua_s = ra_r; end
        M_NEG: begin
          case (step_r)
            3'd0:    begin uop_s = A_NOT; ua_s = ra_r; dst_s = D_T; last_s = 1'b0; end
            default: begin uop_s = A_ADD; ua_s = t_r; ub_s = ONE; end
          endcase
        end
        M_SUB: begin
          case (step_r)
            3'd0:    begin uop_s = A_NOT; ua_s = rb_r; dst_s = D_T; last_s = 1'b0; end
            3'd1:    begin uop_s = A_ADD; ua_s = t_r; ub_s = ONE; dst_s = D_T; last_s = 1'b0; end
            default: begin uop_s = A_ADD; ua_s = ra_r; ub_s = t_r; end
          endcase
        end
        M_OR: begin
          case (step_r)
            3'd0:    begin uop_s = A_NOT; ua_s = ra_r; dst_s = D_T; last_s = 1'b0; end
            3'd1:    begin uop_s = A_NOT; ua_s = rb_r; dst_s = D_U; last_s = 1'b0; end
            3'd2:    begin uop_s = A_AND; ua_s = t_r; ub_s = u_r; dst_s = D_T; last_s = 1'b0; end
            default: begin uop_s = A_NOT; ua_s = t_r; end
          endcase
        end
        M_XOR: begin
          case (step_r)
            3'd0:    begin uop_s = A_AND; ua_s = ra_r; ub_s = rb_r; dst_s = D_T; last_s = 1'b0; end
            3'd1:    begin uop_s = A_NOT; ua_s = t_r; dst_s = D_T; last_s = 1'b0; end
            3'd2:    begin uop_s = A_NOT; ua_s = ra_r; dst_s = D_U; last_s = 1'b0; end
            3'd3:    begin uop_s = A_NOT; ua_s = rb_r; dst_s = D_V; last_s = 1'b0; end
            3'd4:    begin uop_s = A_AND; ua_s = u_r; ub_s = v_r; dst_s = D_U; last_s = 1'b0; end
            3'd5:    begin uop_s = A_NOT; ua_s = u_r; dst_s = D_U; last_s = 1'b0; end
            default: begin uop_s = A_AND; ua_s = t_r; ub_s = u_r; end
          endcase
        end
        default: begin uop_s = A_ADD; ua_s = ZERO; ub_s = ZERO; end
      endcase
    end else begin
      uop_s  = A_ADD;
      ua_s   = ZERO;
      ub_s   = ZERO;
      dst_s  = D_R;
      last_s = 1'b1;
    end
  end

  assign alu_op     = uop_s;
  assign alu_a      = ua_s;
  assign alu_b      = ub_s;
  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign busy       = busy_r;

  // Sequencer FSM: accept a request, step through its micro-ops, hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= 3'd0;
      step_r       <= 3'd0;
      ra_r         <= ZERO;
      rb_r         <= ZERO;
      t_r          <= ZERO;
      u_r          <= ZERO;
      v_r          <= ZERO;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= ZERO;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_r) begin
            op_r        <= req_op;
            ra_r        <= req_a;
            rb_r        <= req_b;
            step_r      <= 3'd0;
            state_r     <= S_EXEC;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_EXEC: begin
          case (dst_s)
            D_T:     t_r <= alu_out;
            D_U:     u_r <= alu_out;
            D_V:     v_r <= alu_out;
            default: resp_data_r <= alu_out;
          endcase
          if (last_s) begin
            state_r      <= S_DONE;
            resp_valid_r <= 1'b1;
          end else begin
            step_r <= step_r + 3'd1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_r      <= S_IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          req_ready_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule
